// File: rtl/nibble_serial_subtractor.sv
// Digit-serial a - b: one DIGIT-bit slice per clock, LSD first, borrow carried in a register.
// Result and flags are registered on entry to DONE and held until the next completion or reset.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             borrow_q, borrow_d, zero_q, zero_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] res_next;

  // Subtraction as a + ~b + 1: the per-digit carry-in is the inverted borrow.
  always_comb begin
    a_dig    = a_q[k_q*DIGIT +: DIGIT];
    b_dig    = b_q[k_q*DIGIT +: DIGIT];
    sum      = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, ~bin_q};
    res_next = res_q;
    res_next[k_q*DIGIT +: DIGIT] = sum[DIGIT-1:0];
  end

  // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    k_d      = k_q;
    bin_d    = bin_q;
    o_d      = o_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          k_d     = '0;
          bin_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_next;
        bin_d = ~sum[DIGIT];
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d  = DONE;
          k_d      = '0;
          o_d      = res_next;
          borrow_d = ~sum[DIGIT];
          zero_d   = (res_next == '0);
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      k_q      <= '0;
      bin_q    <= 1'b0;
      o_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      k_q      <= k_d;
      bin_q    <= bin_d;
      o_q      <= o_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign o      = o_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor computing o = a - b, one 4-bit digit per clock, least-significant digit first.
- Borrow is carried between digits in a register.
- Counterpart to the single-cycle lookahead adder datapath: provides the inverse operation with a start/done handshake for sequenced ALU tests.
- Also produces borrow, zero and signed-overflow flags for compare logic.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of DIGIT
DIGIT, 4, bits processed per cycle; digit count N = WIDTH/DIGIT (default 4)

Ports:
clk     input   1      rising-edge clock
nrst    input   1      asynchronous active-low reset
start   input   1      request; sampled only when busy=0
a       input   WIDTH  minuend; sampled with accepted start
b       input   WIDTH  subtrahend; sampled with accepted start
busy    output  1      high while an operation is in progress
done    output  1      one-cycle pulse when o/flags become valid
o       output  WIDTH  result a - b mod 2^WIDTH
borrow  output  1      1 when a < b unsigned
zero    output  1      1 when result == 0
ovf     output  1      signed two's-complement overflow

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (nrst). On nrst=0, all state clears immediately:
  - state=IDLE; busy=0, done=0
  - o=0, borrow=0, zero=0, ovf=0
  - internal operand, result and digit-counter registers = 0
- States:
  - IDLE: busy=0. If start=1, latch a and b, set digit index k=0 and borrow-in=0, then go to RUN.
  - RUN: busy=1. Each cycle:
    - compute digit k: {cout, d} = a_k + ~b_k + ~bin, over a DIGIT-bit slice
    - write d into result bits [k*DIGIT +: DIGIT]
    - set bin <= ~cout
    - k increments
    - after digit N-1, go to DONE
  - DONE: busy=0, done=1 for exactly this cycle.
    - If start=1 in this cycle, accept the new operands and go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Latency: start accepted on edge T; digits are processed on edges T+1 .. T+N; done is high during the cycle after edge T+N. Default: done is seen 4 cycles after the start edge. Throughput is one operation per N+1 cycles.
- Output registers:
  - o, borrow, zero and ovf update only on the edge entering DONE.
  - They hold their value until the next DONE or reset, and are unchanged during RUN.
- Flags:
  - borrow = final bin (equivalently a < b unsigned)
  - zero = (result == 0)
  - ovf = (a[MSB] != b[MSB]) && (o[MSB] != a[MSB])
- Handshake and boundary rules:
  - start while in RUN is ignored; latched operands are unchanged.
  - Changes on a/b after acceptance have no effect.
  - a == b gives o=0, zero=1, borrow=0.
  - b=0 gives o=a, borrow=0, ovf=0.
  - Wrap-around is modulo 2^WIDTH. No saturation.
- Reset mid-operation: the partial result is discarded and done is not pulsed. The first start after nrst deasserts begins a fresh operation.

Test Plan:
- Reset, then start with a=0x0005, b=0x0003 -> busy=1 for 4 cycles, then done pulse; o=0x0002, borrow=0, zero=0, ovf=0.
- a=0x0003, b=0x0005 -> o=0xFFFE, borrow=1, zero=0, ovf=0. a=0x1234, b=0x1234 -> o=0x0000, zero=1, borrow=0.
- Signed edges:
  - a=0x8000, b=0x0001 -> o=0x7FFF, ovf=1, borrow=0.
  - a=0x7FFF, b=0xFFFF -> o=0x8000, ovf=1, borrow=1.
- Cross-digit borrow ripple: a=0x1000, b=0x0001 -> o=0x0FFF. Start pulsed again mid-RUN with a=0xFFFF -> ignored, result unchanged. Done is a single-cycle pulse.
- Back-to-back:
  - first op a=0x0010, b=0x0001; during its DONE cycle, assert start with a=0x0000, b=0x0001
  - expect first done with o=0x000F, then second done exactly 5 cycles later with o=0xFFFF, borrow=1
- Reset mid-op: drop nrst asynchronously during RUN digit 2 -> busy, done and outputs go to 0 immediately with no done pulse. A subsequent start with a=0x0009, b=0x0004 -> o=0x0005.
